// File: rtl/vec_packer_pkg.sv
// Shared word-detect parameters and small helpers for the vector packer.
package vec_packer_pkg;

  // Element width shared across the word-detect datapath.
  localparam int WD_BW        = 8;
  // Defaults; the parent overrides these from NUM_FILTERS / FRAME_LEN.
  localparam int WD_PACK_LEN  = 8;
  localparam int WD_FRAME_LEN = 50;

  // Counter width for a modulo-n counter, kept at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_packer.sv
// Packs PACK_LEN consecutive scalar conv outputs into one vector beat with
// valid/last/ready handshaking, frame tracking and a sticky framing error.
module vec_packer
  import vec_packer_pkg::*;
#(
  parameter int BW        = WD_BW,
  parameter int PACK_LEN  = WD_PACK_LEN,
  parameter int FRAME_LEN = WD_FRAME_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [BW-1:0]          data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [PACK_LEN*BW-1:0] data_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i,
  output logic                   err_o
);

  localparam int DW = PACK_LEN * BW;
  localparam int EW = cnt_width(PACK_LEN);
  localparam int VW = cnt_width(FRAME_LEN);
  localparam logic [EW-1:0] ELEM_MAX = EW'(PACK_LEN - 1);
  localparam logic [VW-1:0] VEC_MAX  = VW'(FRAME_LEN - 1);

  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] data_q, data_d;
  logic [EW-1:0] elem_cnt_q, elem_cnt_d;
  logic [VW-1:0] vec_cnt_q, vec_cnt_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic          accept;
  logic          elem_full;
  logic          frame_full;
  logic          closing;
  logic          close_last;
  logic [DW-1:0] merged;

  // The output register can take a new vector whenever it is empty or being drained.
  assign ready_o = !valid_q || ready_i;

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign err_o   = err_q;

  // Handshake qualifiers and the accumulator with the incoming element merged in.
  always_comb begin
    accept     = valid_i && ready_o;
    elem_full  = (elem_cnt_q == ELEM_MAX);
    frame_full = (vec_cnt_q == VEC_MAX);
    closing    = accept && (elem_full || last_i);
    close_last = last_i || frame_full;
    merged     = acc_q;
    for (int k = 0; k < PACK_LEN; k++) begin
      if (elem_cnt_q == EW'(k)) merged[k*BW +: BW] = data_i;
    end
  end

  // Next-state for accumulator, counters, output register and error flag.
  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves it unassigned, which would infer a latch.
    acc_d      = acc_q;
    data_d     = data_q;
    elem_cnt_d = elem_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = err_q;

    if (accept) begin
      if (closing) begin
        acc_d      = '0;
        elem_cnt_d = '0;
        data_d     = merged;
        last_d     = close_last;
        vec_cnt_d  = close_last ? '0 : vec_cnt_q + VW'(1);
        err_d      = err_q
                   | (last_i && !elem_full)
                   | (last_i && !frame_full)
                   | (frame_full && !last_i);
      end else begin
        acc_d      = merged;
        elem_cnt_d = elem_cnt_q + EW'(1);
      end
    end

    if (closing)      valid_d = 1'b1;
    else if (ready_i) valid_d = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      // NOTE: the data registers are reset too, so data_o reads zero and a partial vector is dropped.
      acc_q      <= '0;
      data_q     <= '0;
      elem_cnt_q <= '0;
      vec_cnt_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      data_q     <= data_d;
      elem_cnt_q <= elem_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_vec_packer.sv
// Self-checking bench for vec_packer: directed steps plus randomized data,
// compared every cycle against a queue-based behavioural model.
module tb_vec_packer;
  import vec_packer_pkg::*;

  localparam int BW = 8;
  localparam int PL = 8;
  localparam int FL = 50;
  localparam int DW = PL * BW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [BW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          ready_i = 1'b1;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          last_o;
  logic          err_o;

  vec_packer #(.BW(BW), .PACK_LEN(PL), .FRAME_LEN(FL)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: elements of the vector being built, and the held output.
  logic [BW-1:0] cur[$];
  int            vcnt;
  bit            m_valid;
  bit            m_last;
  bit            m_err;
  logic [DW-1:0] m_data;

  // Handshakes observed on the DUT since the last reset.
  int n_vec, n_last, last_idx;
  bit dummy;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [BW-1:0] d, input bit l, input bit r, input bit rst);
    bit fire_out, acc, forced;
    int n;
    if (rst) begin
      cur.delete();
      vcnt = 0; m_valid = 0; m_last = 0; m_err = 0; m_data = '0;
      return;
    end
    fire_out = m_valid && r;
    acc      = v && (!m_valid || r);
    if (acc) begin
      cur.push_back(d);
      if (cur.size() == PL || l) begin
        n      = vcnt + 1;
        forced = (n == FL);
        if (l && cur.size() != PL) m_err = 1;
        if (l && n != FL)          m_err = 1;
        if (forced && !l)          m_err = 1;
        m_data = '0;
        foreach (cur[k]) m_data[k*BW +: BW] = cur[k];
        m_last  = l || forced;
        vcnt    = m_last ? 0 : n;
        m_valid = 1;
        cur.delete();
        return;
      end
    end
    if (fire_out) m_valid = 0;
  endtask

  // One clock: drive inputs mid-low-phase, check outputs, advance the model.
  task automatic cyc(input bit v, input logic [BW-1:0] d, input bit l, input bit r,
                     input bit rst, output bit acc);
    @(negedge clk_i);
    rst_i = rst; valid_i = v; data_i = d; last_i = l; ready_i = r;
    #1;
    chk("valid_o", DW'(valid_o), DW'(m_valid));
    chk("ready_o", DW'(ready_o), DW'(!m_valid || r));
    chk("err_o",   DW'(err_o),   DW'(m_err));
    if (m_valid) begin
      chk("data_o", data_o, m_data);
      chk("last_o", DW'(last_o), DW'(m_last));
    end
    if (!rst && valid_o && r) begin
      n_vec++;
      if (last_o) begin n_last++; last_idx = n_vec; end
    end
    acc = !rst && v && (!m_valid || r);
    model_step(v, d, l, r, rst);
  endtask

  task automatic put(input logic [BW-1:0] d, input bit l);
    cyc(1'b1, d, l, 1'b1, 1'b0, dummy);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, dummy);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, dummy);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, dummy);
    n_vec = 0; n_last = 0; last_idx = 0;
  endtask

  initial begin
    bit acc;
    int sent;
    int guard;

    // Reset state.
    do_reset();
    idle();
    chk("rst_valid", DW'(valid_o), '0);
    chk("rst_data",  data_o, '0);
    chk("rst_err",   DW'(err_o), '0);

    // Test 1: 0x01..0x08 back-to-back.
    for (int i = 1; i <= 8; i++) put(BW'(i), 1'b0);
    idle();
    chk("t1_valid", DW'(valid_o), DW'(1));
    chk("t1_data",  data_o, 64'h0807060504030201);
    chk("t1_last",  DW'(last_o), '0);
    chk("t1_err",   DW'(err_o), '0);

    // Test 2: two well-formed frames of 400 elements.
    do_reset();
    for (int i = 0; i < PL*FL; i++) put(BW'($urandom), i == PL*FL-1);
    idle();
    chk("t2_nvec",  DW'(n_vec), DW'(50));
    chk("t2_nlast", DW'(n_last), DW'(1));
    chk("t2_lidx",  DW'(last_idx), DW'(50));
    for (int i = 0; i < PL*FL; i++) put(BW'($urandom), i == PL*FL-1);
    idle();
    chk("t2b_nvec",  DW'(n_vec), DW'(100));
    chk("t2b_nlast", DW'(n_last), DW'(2));
    chk("t2b_lidx",  DW'(last_idx), DW'(100));
    chk("t2_err",    DW'(err_o), '0);

    // Test 3: back-pressure, then a randomly throttled full frame.
    do_reset();
    sent = 0;
    for (int i = 0; i < PL; i++) begin put(BW'($urandom), 1'b0); sent++; end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, BW'($urandom), 1'b0, 1'b0, 1'b0, acc);
      chk("t3_stall_ready", DW'(ready_o), '0);
      if (acc) sent++;
    end
    guard = 0;
    while (sent < PL*FL && guard < 5000) begin
      cyc(($urandom_range(3) != 0), BW'($urandom), sent == PL*FL-1,
          ($urandom_range(1) != 0), 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    chk("t3_budget", DW'(sent), DW'(PL*FL));
    for (int i = 0; i < 4; i++) idle();
    chk("t3_nvec",  DW'(n_vec), DW'(50));
    chk("t3_lidx",  DW'(last_idx), DW'(50));
    chk("t3_err",   DW'(err_o), '0);

    // Test 4: short, zero-padded final vector.
    do_reset();
    put(8'hAA, 1'b0);
    put(8'hBB, 1'b0);
    put(8'hCC, 1'b1);
    idle();
    chk("t4_data", data_o, 64'h0000000000CCBBAA);
    chk("t4_last", DW'(last_o), DW'(1));
    chk("t4_err",  DW'(err_o), DW'(1));
    for (int i = 0; i < 2*PL; i++) put(BW'($urandom), 1'b0);
    idle();
    chk("t4_sticky", DW'(err_o), DW'(1));

    // Test 5: reset drops a partial vector.
    do_reset();
    for (int i = 0; i < 5; i++) put(BW'($urandom), 1'b0);
    do_reset();
    idle();
    chk("t5_valid", DW'(valid_o), '0);
    chk("t5_err",   DW'(err_o), '0);
    for (int i = 0; i < 8; i++) put(BW'(8'h10 + i), 1'b0);
    idle();
    chk("t5_data", data_o, 64'h1716151413121110);

    // Test 6: long frame, forced last on vector 50.
    do_reset();
    for (int i = 0; i < PL*(FL+1); i++) put(BW'($urandom), 1'b0);
    idle();
    chk("t6_nvec",  DW'(n_vec), DW'(51));
    chk("t6_nlast", DW'(n_last), DW'(1));
    chk("t6_lidx",  DW'(last_idx), DW'(50));
    chk("t6_err",   DW'(err_o), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
